// File: rtl/noc_to_cpu_arbiter_if.sv
// Handshake bundle between the flit requesters, the NoC-to-CPU arbiter and the deflitizer.
interface noc_to_cpu_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int FLIT_W  = 128
);
    logic [FLIT_W-1:0]  req_flit [NUM_REQ];
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_tail;
    logic [NUM_REQ-1:0] req_ready;
    logic [FLIT_W-1:0]  poped_flit;
    logic               poped_flit_valid;
    logic               poped_flit_ready;

    // Arbiter side: takes flits from the requesters and presents one to the deflitizer.
    modport master (
        input  req_flit,
        input  req_valid,
        input  req_tail,
        input  poped_flit_ready,
        output req_ready,
        output poped_flit,
        output poped_flit_valid
    );

    // Environment side: requester queues and deflitizer.
    modport slave (
        output req_flit,
        output req_valid,
        output req_tail,
        output poped_flit_ready,
        input  req_ready,
        input  poped_flit,
        input  poped_flit_valid
    );
endinterface

// File: rtl/noc_to_cpu_arbiter.sv
// Packet-level round-robin arbiter in front of the NoC-to-CPU deflitizer.
// A grant is held from the first flit of a packet until its tail flit (or a
// watchdog release), and the chosen flit is forwarded through a one-entry
// output register that drives the deflitizer handshake.
module noc_to_cpu_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int MAX_PKT_FLITS = 16,
    parameter int FLIT_W        = 128
) (
    input  logic                       nocclk,
    input  logic                       rst_n,
    noc_to_cpu_arbiter_if.master       bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       watchdog_err,
    output logic [15:0]                pkt_count
);

    localparam int GID_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_PKT_FLITS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PKT_FLITS);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_e;

    state_e              state_q, state_d;
    logic [GID_W-1:0]    last_grant_q, last_grant_d;
    logic [GID_W-1:0]    grant_id_q, grant_id_d;
    logic [CNT_W-1:0]    flit_cnt_q, flit_cnt_d;
    logic [FLIT_W-1:0]   out_flit_q, out_flit_d;
    logic                out_valid_q, out_valid_d;
    logic                wd_err_q, wd_err_d;
    logic [15:0]         pkt_count_q, pkt_count_d;

    logic                arb_found;
    logic [GID_W-1:0]    arb_sel;
    logic [NUM_REQ-1:0]  req_ready_w;
    logic                xfer;
    logic [CNT_W-1:0]    cnt_inc;

    // Round-robin pick: first valid requester after the last completed grant.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        arb_found = 1'b0;
        arb_sel   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(last_grant_q) + k) % NUM_REQ;
            if (!arb_found && bus.req_valid[GID_W'(idx)]) begin
                arb_found = 1'b1;
                arb_sel   = GID_W'(idx);
            end
        end
    end

    // Only the locked requester may push, and only when the output register can take a flit.
    always_comb begin
        req_ready_w = '0;
        if (state_q == ST_LOCKED) begin
            req_ready_w[grant_id_q] = !out_valid_q || bus.poped_flit_ready;
        end
    end

    assign xfer    = (state_q == ST_LOCKED) && bus.req_valid[grant_id_q] && req_ready_w[grant_id_q];
    assign cnt_inc = flit_cnt_q + CNT_W'(1);

    // Next-state logic: arbitration, packet lock/release, watchdog and output register.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        flit_cnt_d   = flit_cnt_q;
        out_flit_d   = out_flit_q;
        out_valid_d  = out_valid_q;
        wd_err_d     = 1'b0;
        pkt_count_d  = pkt_count_q;

        // Deflitizer took the held flit; a transfer below may refill it in the same cycle.
        if (out_valid_q && bus.poped_flit_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    state_d    = ST_LOCKED;
                    grant_id_d = arb_sel;
                    flit_cnt_d = '0;
                end
            end
            ST_LOCKED: begin
                if (xfer) begin
                    out_flit_d  = bus.req_flit[grant_id_q];
                    out_valid_d = 1'b1;
                    flit_cnt_d  = cnt_inc;
                    if (bus.req_tail[grant_id_q]) begin
                        state_d      = ST_IDLE;
                        last_grant_d = grant_id_q;
                        pkt_count_d  = pkt_count_q + 16'd1;
                    end else if (cnt_inc == MAX_CNT) begin
                        // Packet overran the flit limit: force the grant free.
                        state_d      = ST_IDLE;
                        last_grant_d = grant_id_q;
                        wd_err_d     = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any lock and discards the held flit.
    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GID_W'(NUM_REQ - 1);
            grant_id_q   <= '0;
            flit_cnt_q   <= '0;
            out_flit_q   <= '0;
            out_valid_q  <= 1'b0;
            wd_err_q     <= 1'b0;
            pkt_count_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            flit_cnt_q   <= flit_cnt_d;
            out_flit_q   <= out_flit_d;
            out_valid_q  <= out_valid_d;
            wd_err_q     <= wd_err_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    assign bus.req_ready        = req_ready_w;
    assign bus.poped_flit       = out_flit_q;
    assign bus.poped_flit_valid = out_valid_q;
    assign grant_id             = grant_id_q;
    assign busy                 = (state_q == ST_LOCKED);
    assign watchdog_err         = wd_err_q;
    assign pkt_count            = pkt_count_q;

endmodule

// File: tb/tb_noc_to_cpu_arbiter.sv
// Scoreboard bench for noc_to_cpu_arbiter: requester models feed per-source
// flit queues, the expected output order and grant order are queued by hand,
// and a monitor checks every flit the deflitizer accepts.
module tb_noc_to_cpu_arbiter;

    localparam int NUM_REQ       = 4;
    localparam int MAX_PKT_FLITS = 4;
    localparam int FLIT_W        = 128;

    typedef logic [FLIT_W-1:0] flit_t;
    typedef struct {
        flit_t flit;
        logic  tail;
        int    delay;
    } src_t;

    logic        nocclk = 1'b0;
    logic        rst_n;
    logic [1:0]  grant_id;
    logic        busy;
    logic        watchdog_err;
    logic [15:0] pkt_count;

    noc_to_cpu_arbiter_if #(.NUM_REQ(NUM_REQ), .FLIT_W(FLIT_W)) bus ();

    noc_to_cpu_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .MAX_PKT_FLITS(MAX_PKT_FLITS),
        .FLIT_W       (FLIT_W)
    ) dut (
        .nocclk      (nocclk),
        .rst_n       (rst_n),
        .bus         (bus),
        .grant_id    (grant_id),
        .busy        (busy),
        .watchdog_err(watchdog_err),
        .pkt_count   (pkt_count)
    );

    always #5 nocclk = ~nocclk;

    src_t               src_q [NUM_REQ][$];
    flit_t              exp_q[$];
    int                 exp_grant_q[$];
    logic [NUM_REQ-1:0] fire = '0;
    int                 errors = 0;
    int                 checks = 0;
    int                 wd_seen = 0;
    bit                 rdy_mode = 1'b0;
    int                 cyc = 0;
    bit                 busy_prev = 1'b0;
    int                 exp_pkts = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic flit_t make_flit(input int r, input int p, input int f);
        logic [103:0] body;
        body = {13{8'h5A}} ^ 104'(r * 4096 + p * 64 + f);
        return {8'(r), 8'(p), 8'(f), body};
    endfunction

    task automatic push_src_flit(input int r, input int p, input int f, input logic tail, input int delay);
        src_t s;
        s.flit  = make_flit(r, p, f);
        s.tail  = tail;
        s.delay = delay;
        src_q[r].push_back(s);
    endtask

    task automatic push_src_pkt(input int r, input int p, input int n, input int delay);
        for (int f = 0; f < n; f++) begin
            push_src_flit(r, p, f, (f == n - 1), (f == 0) ? delay : 0);
        end
    endtask

    task automatic expect_pkt(input int r, input int p, input int n);
        for (int f = 0; f < n; f++) begin
            exp_q.push_back(make_flit(r, p, f));
        end
    endtask

    task automatic clear_env();
        for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
        exp_q.delete();
        exp_grant_q.delete();
        fire = '0;
    endtask

    task automatic do_reset();
        @(negedge nocclk);
        #2;
        rst_n = 1'b0;
        clear_env();
        repeat (2) @(negedge nocclk);
        #2;
        rst_n = 1'b1;
        exp_pkts = 0;
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < max_cycles) begin
            @(negedge nocclk);
            #3;
            n++;
            done = (exp_q.size() == 0) && (exp_grant_q.size() == 0) && !busy && !bus.poped_flit_valid;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (src_q[i].size() != 0) done = 1'b0;
            end
        end
        check({name, "_drained"}, {127'b0, done}, 128'd1);
    endtask

    // Requester and deflitizer models: apply last cycle's accepts, then drive this cycle.
    always @(negedge nocclk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        fire = '0;
        cyc++;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_q[i].size() == 0) begin
                bus.req_valid[i] = 1'b0;
                bus.req_tail[i]  = 1'b0;
                bus.req_flit[i]  = '0;
            end else if (src_q[i][0].delay > 0) begin
                src_q[i][0].delay = src_q[i][0].delay - 1;
                bus.req_valid[i] = 1'b0;
                bus.req_tail[i]  = 1'b0;
                bus.req_flit[i]  = '0;
            end else begin
                bus.req_valid[i] = 1'b1;
                bus.req_tail[i]  = src_q[i][0].tail;
                bus.req_flit[i]  = src_q[i][0].flit;
            end
        end
        bus.poped_flit_ready = !rdy_mode || (cyc % 5 == 0);
        #1;
        fire = bus.req_valid & bus.req_ready;
    end

    // Monitor: grant order, delivered flits and the backpressure rule.
    always @(negedge nocclk) begin
        #1;
        if (watchdog_err) wd_seen++;
        if (rst_n) begin
            if (busy && !busy_prev) begin
                if (exp_grant_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL grant_unexpected: got grant %0d with none queued", grant_id);
                end else begin
                    int eg;
                    eg = exp_grant_q.pop_front();
                    check("grant_order", {126'b0, grant_id}, 128'(eg));
                end
            end
            if (bus.poped_flit_valid && !bus.poped_flit_ready) begin
                check("backpressure_ready", {124'b0, bus.req_ready}, 128'd0);
            end
            if (bus.poped_flit_valid && bus.poped_flit_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL flit_unexpected: got %0h with none queued", bus.poped_flit);
                end else begin
                    flit_t ef;
                    ef = exp_q.pop_front();
                    check("flit_data", bus.poped_flit, ef);
                end
            end
        end
        busy_prev = busy;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        rst_n                = 1'b0;
        bus.req_valid        = '0;
        bus.req_tail         = '0;
        bus.poped_flit_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) bus.req_flit[i] = '0;

        // Reset values.
        repeat (2) @(negedge nocclk);
        #3;
        check("rst_busy", {127'b0, busy}, 128'd0);
        check("rst_valid", {127'b0, bus.poped_flit_valid}, 128'd0);
        check("rst_flit", bus.poped_flit, 128'd0);
        check("rst_ready", {124'b0, bus.req_ready}, 128'd0);
        check("rst_grant", {126'b0, grant_id}, 128'd0);
        check("rst_wd", {127'b0, watchdog_err}, 128'd0);
        check("rst_pkt", {112'b0, pkt_count}, 128'd0);
        rst_n = 1'b1;

        // Single requester, 3-flit packet, deflitizer always ready.
        @(negedge nocclk);
        #3;
        wd_seen = 0;
        push_src_pkt(0, 0, 3, 0);
        expect_pkt(0, 0, 3);
        exp_grant_q.push_back(0);
        @(negedge nocclk);
        #2;
        check("t1_idle_ready", {124'b0, bus.req_ready}, 128'd0);
        @(negedge nocclk);
        #2;
        check("t1_ready_cycle1", {124'b0, bus.req_ready}, 128'b0001);
        @(negedge nocclk);
        #2;
        check("t1_latency_valid", {127'b0, bus.poped_flit_valid}, 128'd1);
        check("t1_latency_data", bus.poped_flit, make_flit(0, 0, 0));
        wait_drain("t1", 100);
        exp_pkts = 1;
        check("t1_pkt_count", {112'b0, pkt_count}, 128'(exp_pkts));
        check("t1_no_watchdog", 128'(wd_seen), 128'd0);

        // Round-robin among requesters 0, 1 and 3 with two 2-flit packets each.
        do_reset();
        for (int p = 0; p < 2; p++) begin
            push_src_pkt(0, p, 2, 0);
            push_src_pkt(1, p, 2, 0);
            push_src_pkt(3, p, 2, 0);
        end
        for (int p = 0; p < 2; p++) begin
            expect_pkt(0, p, 2);
            exp_grant_q.push_back(0);
            expect_pkt(1, p, 2);
            exp_grant_q.push_back(1);
            expect_pkt(3, p, 2);
            exp_grant_q.push_back(3);
        end
        wait_drain("t2", 200);
        exp_pkts = 6;
        check("t2_pkt_count", {112'b0, pkt_count}, 128'(exp_pkts));

        // Backpressure: deflitizer ready one cycle in five; last grant was 3.
        rdy_mode = 1'b1;
        push_src_pkt(1, 2, 3, 0);
        push_src_pkt(2, 2, 3, 0);
        expect_pkt(1, 2, 3);
        exp_grant_q.push_back(1);
        expect_pkt(2, 2, 3);
        exp_grant_q.push_back(2);
        wait_drain("t3", 300);
        rdy_mode = 1'b0;
        exp_pkts = 8;
        check("t3_pkt_count", {112'b0, pkt_count}, 128'(exp_pkts));

        // Watchdog: requester 2 sends 4 non-tail flits, then 3 and 0 get their turn.
        wd_seen = 0;
        for (int f = 0; f < 4; f++) push_src_flit(2, 3, f, 1'b0, 0);
        push_src_pkt(2, 4, 1, 0);
        push_src_pkt(3, 3, 2, 3);
        push_src_pkt(0, 3, 1, 3);
        expect_pkt(2, 3, 4);
        exp_grant_q.push_back(2);
        expect_pkt(3, 3, 2);
        exp_grant_q.push_back(3);
        expect_pkt(0, 3, 1);
        exp_grant_q.push_back(0);
        expect_pkt(2, 4, 1);
        exp_grant_q.push_back(2);
        wait_drain("t4", 200);
        exp_pkts = 11;
        check("t4_wd_pulses", 128'(wd_seen), 128'd1);
        check("t4_pkt_count", {112'b0, pkt_count}, 128'(exp_pkts));

        // Lock under gap: requester 1 pauses 10 cycles mid-packet while 0 waits.
        push_src_flit(1, 5, 0, 1'b0, 0);
        push_src_flit(1, 5, 1, 1'b0, 10);
        push_src_flit(1, 5, 2, 1'b1, 0);
        push_src_pkt(0, 5, 1, 3);
        expect_pkt(1, 5, 3);
        exp_grant_q.push_back(1);
        expect_pkt(0, 5, 1);
        exp_grant_q.push_back(0);
        repeat (6) @(negedge nocclk);
        #2;
        check("t5_gap_grant", {126'b0, grant_id}, 128'd1);
        check("t5_gap_busy", {127'b0, busy}, 128'd1);
        check("t5_gap_ready", {124'b0, bus.req_ready}, 128'b0010);
        wait_drain("t5", 100);
        exp_pkts = 13;
        check("t5_pkt_count", {112'b0, pkt_count}, 128'(exp_pkts));

        // Reset while locked with a flit held in the output register.
        rdy_mode = 1'b1;
        push_src_pkt(2, 6, 3, 0);
        expect_pkt(2, 6, 3);
        exp_grant_q.push_back(2);
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            @(negedge nocclk);
            #2;
            found = busy && bus.poped_flit_valid;
        end
        check("t6_locked_with_flit", {127'b0, found}, 128'd1);
        rst_n = 1'b0;
        #1;
        check("t6_async_busy", {127'b0, busy}, 128'd0);
        check("t6_async_valid", {127'b0, bus.poped_flit_valid}, 128'd0);
        check("t6_async_flit", bus.poped_flit, 128'd0);
        check("t6_async_ready", {124'b0, bus.req_ready}, 128'd0);
        check("t6_async_grant", {126'b0, grant_id}, 128'd0);
        check("t6_async_pkt", {112'b0, pkt_count}, 128'd0);
        clear_env();
        rdy_mode = 1'b0;
        repeat (2) @(negedge nocclk);
        #2;
        rst_n = 1'b1;
        @(negedge nocclk);
        #3;
        push_src_pkt(3, 7, 1, 0);
        push_src_pkt(0, 7, 1, 0);
        expect_pkt(0, 7, 1);
        exp_grant_q.push_back(0);
        expect_pkt(3, 7, 1);
        exp_grant_q.push_back(3);
        wait_drain("t6", 100);
        exp_pkts = 2;
        check("t6_pkt_count", {112'b0, pkt_count}, 128'(exp_pkts));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
